// File: rtl/fir_coef_ctrl.sv
// Double-buffered coefficient bank controller for the decimating FIR.
// A streamed coefficient set fills the shadow bank; once a complete set has
// landed, the banks swap on a cycle where the FIR is idle. If the FIR stays
// busy for too long, the swap is forced.
module fir_coef_ctrl #(
  parameter int TAP_COUNT    = 121,
  parameter int COEF_WIDTH   = 16,
  parameter int SWAP_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_tvalid,
  output logic                            cfg_tready,
  input  logic [COEF_WIDTH-1:0]           cfg_tdata,
  input  logic                            cfg_tlast,
  input  logic                            sample_en,
  output logic [TAP_COUNT*COEF_WIDTH-1:0] coef_bus,
  output logic                            bank_sel,
  output logic                            swap_done,
  output logic                            swap_forced,
  output logic                            err_short,
  output logic                            err_long,
  input  logic                            err_clr
);

  localparam int IDX_W = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int TMR_W = $clog2(SWAP_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_COUNT - 1);
  localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(SWAP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ARMED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             bank_sel_q, bank_sel_d;
  logic             swap_done_q, swap_done_d;
  logic             swap_forced_q, swap_forced_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;

  logic             beat;
  logic             wr_en;
  logic [IDX_W-1:0] cur_idx;
  logic             set_short;
  logic             set_long;

  // No beat is taken while the completed set waits to be swapped in.
  assign cfg_tready = !rst && (state_q != ARMED);
  assign beat       = cfg_tvalid && cfg_tready;

  // Next-state logic: load sequencing, length checking and swap timing.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    bank_sel_d    = bank_sel_q;
    swap_done_d   = 1'b0;
    swap_forced_d = 1'b0;
    set_short     = 1'b0;
    set_long      = 1'b0;
    wr_en         = 1'b0;
    // The first beat of a set always lands in tap 0, whatever idx holds.
    cur_idx       = (state_q == IDLE) ? '0 : idx_q;

    case (state_q)
      IDLE, LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (cfg_tlast) begin
            idx_d = '0;
            if (cur_idx == LAST_IDX) begin
              state_d = ARMED;
            end else begin
              set_short = 1'b1;
              state_d   = IDLE;
            end
          end else if (cur_idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d   = cur_idx + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (beat && cfg_tlast) begin
          set_long = 1'b1;
          state_d  = IDLE;
        end
      end
      ARMED: begin
        if (!sample_en || (timer_q == LAST_TMR)) begin
          bank_sel_d    = !bank_sel_q;
          swap_done_d   = 1'b1;
          swap_forced_d = sample_en;
          timer_d       = '0;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error event outranks a simultaneous clear.
    err_short_d = set_short || (err_short_q && !err_clr);
    err_long_d  = set_long  || (err_long_q  && !err_clr);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      bank_sel_q    <= 1'b0;
      swap_done_q   <= 1'b0;
      swap_forced_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      bank_sel_q    <= bank_sel_d;
      swap_done_q   <= swap_done_d;
      swap_forced_q <= swap_forced_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
    end
  end

  // One register pair per tap; only the shadow copy is ever written.
  for (genvar gi = 0; gi < TAP_COUNT; gi++) begin : g_tap
    logic [COEF_WIDTH-1:0] b0_q;
    logic [COEF_WIDTH-1:0] b1_q;

    // Shadow-bank write of the beat addressed to this tap.
    always_ff @(posedge clk) begin
      if (rst) begin
        b0_q <= '0;
        b1_q <= '0;
      end else if (wr_en && (cur_idx == IDX_W'(gi))) begin
        if (bank_sel_q) b0_q <= cfg_tdata;
        else            b1_q <= cfg_tdata;
      end
    end

    assign coef_bus[gi*COEF_WIDTH +: COEF_WIDTH] = bank_sel_q ? b1_q : b0_q;
  end

  assign bank_sel    = bank_sel_q;
  assign swap_done   = swap_done_q;
  assign swap_forced = swap_forced_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Randomized scoreboard bench for fir_coef_ctrl. The driver models the
// controller as "collect beats until tlast, classify by count, then swap
// after the FIR's first idle cycle or after the timeout" and queues the
// expected swap events; an independent monitor checks every swap and that
// the active coefficients hold still in between.
module tb_fir_coef_ctrl;
  localparam int T  = 121;
  localparam int W  = 16;
  localparam int TO = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_tvalid;
  logic           cfg_tready;
  logic [W-1:0]   cfg_tdata;
  logic           cfg_tlast;
  logic           sample_en;
  logic [T*W-1:0] coef_bus;
  logic           bank_sel;
  logic           swap_done;
  logic           swap_forced;
  logic           err_short;
  logic           err_long;
  logic           err_clr;

  fir_coef_ctrl #(.TAP_COUNT(T), .COEF_WIDTH(W), .SWAP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .cfg_tdata(cfg_tdata), .cfg_tlast(cfg_tlast),
    .sample_en(sample_en), .coef_bus(coef_bus), .bank_sel(bank_sel),
    .swap_done(swap_done), .swap_forced(swap_forced),
    .err_short(err_short), .err_long(err_long), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             obs;
    bit             forced;
    bit             sel;
    logic [T*W-1:0] bus;
  } swap_t;

  swap_t          sq[$];
  logic [W-1:0]   cur[$];
  logic [T*W-1:0] done_bus;
  int             cyc = 0;
  int             total = 0;
  int             passed = 0;
  bit             rst_q = 1'b0;
  bit             armed_m = 1'b0;
  bit             sel_m = 1'b0;
  bit             m_short = 1'b0;
  bit             m_long = 1'b0;
  logic [T*W-1:0] mon_bus = '0;
  bit             mon_sel = 1'b0;
  swap_t          mon_e;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic bus_chk(input string name, input logic [T*W-1:0] act, input logic [T*W-1:0] exp);
    int bad;
    bad = -1;
    for (int i = T - 1; i >= 0; i--)
      if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
    total++;
    if (bad < 0) passed++;
    else $display("FAIL %s: tap %0d got 0x%0h expected 0x%0h at cycle %0d",
                  name, bad, act[bad*W +: W], exp[bad*W +: W], cyc);
  endtask

  // Monitor: swap events against the scoreboard, stability otherwise.
  always @(negedge clk) begin
    if (rst_q) begin
      mon_bus = '0;
      mon_sel = 1'b0;
      sq.delete();
    end
    if (swap_done === 1'b1) begin
      if (sq.size() == 0) begin
        chk("swap_unexpected", 1'b0, 1, 0);
      end else begin
        mon_e = sq.pop_front();
        chk("swap_cycle", cyc == mon_e.obs, cyc, mon_e.obs);
        chk("swap_forced", swap_forced === mon_e.forced, swap_forced, mon_e.forced);
        chk("bank_sel_swap", bank_sel === mon_e.sel, bank_sel, mon_e.sel);
        bus_chk("coef_bus_swap", coef_bus, mon_e.bus);
        $display("swap at cycle %0d bank_sel=%0d forced=%0d", cyc, bank_sel, swap_forced);
        mon_bus = mon_e.bus;
        mon_sel = mon_e.sel;
      end
    end else begin
      chk("swap_done_low", swap_done === 1'b0, swap_done, 0);
      chk("swap_forced_low", swap_forced === 1'b0, swap_forced, 0);
      chk("bank_sel_hold", bank_sel === mon_sel, bank_sel, mon_sel);
      bus_chk("coef_bus_hold", coef_bus, mon_bus);
      if (sq.size() > 0 && cyc >= sq[0].obs) begin
        chk("swap_missing", 1'b0, cyc, sq[0].obs);
        mon_e   = sq.pop_front();
        mon_bus = mon_e.bus;
        mon_sel = mon_e.sel;
      end
    end
  end

  // One clock of stimulus plus the reference model's view of that edge.
  // ev: 0 nothing, 1 complete set, 2 short set, 3 long set.
  task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit se,
                      input bit ec, output bit acc, output int ev);
    bit rdy;
    cfg_tvalid = v;
    cfg_tdata  = d;
    cfg_tlast  = l;
    sample_en  = se;
    err_clr    = ec;
    rdy = !rst && !armed_m;
    @(negedge clk);
    chk("cfg_tready", cfg_tready === rdy, cfg_tready, rdy);
    chk("err_short", err_short === m_short, err_short, m_short);
    chk("err_long", err_long === m_long, err_long, m_long);
    @(posedge clk);
    #1;
    acc = v && rdy;
    ev  = 0;
    if (rst) begin
      cur.delete();
      m_short = 1'b0;
      m_long  = 1'b0;
      sel_m   = 1'b0;
    end else begin
      if (acc) begin
        cur.push_back(d);
        if (l) begin
          if (cur.size() == T) begin
            ev = 1;
            for (int i = 0; i < T; i++) done_bus[i*W +: W] = cur[i];
          end else if (cur.size() < T) begin
            ev = 2;
          end else begin
            ev = 3;
          end
          $display("set of %0d beats ends at cycle %0d (class %0d)", cur.size(), cyc, ev);
          cur.delete();
        end
      end
      m_short = (ev == 2) ? 1'b1 : (ec ? 1'b0 : m_short);
      m_long  = (ev == 3) ? 1'b1 : (ec ? 1'b0 : m_long);
    end
  endtask

  task automatic idle(input int n, input bit ec);
    bit acc;
    int ev;
    for (int i = 0; i < n; i++)
      step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), ec, acc, ev);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    idle(n, 1'b0);
    rst = 1'b0;
  endtask

  // Waiting for the swap: sample_en is high for k cycles, then low.
  task automatic armed(input int k);
    int    n;
    bit    acc;
    int    ev;
    swap_t e;
    n = ((k < TO - 1) ? k : TO - 1) + 1;
    e.obs    = cyc + n;
    e.forced = (k >= TO);
    e.sel    = !sel_m;
    e.bus    = done_bus;
    sq.push_back(e);
    sel_m   = !sel_m;
    armed_m = 1'b1;
    for (int j = 0; j < n; j++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           (j < k), 1'b0, acc, ev);
    armed_m = 1'b0;
  endtask

  // kind 0: tap k holds k+1; kind 1: random data. rst_at >= 0 resets the
  // DUT once that many beats have been accepted.
  task automatic send_set(input int len, input int kind, input int k, input int rst_at);
    int           b;
    bit           v;
    bit           acc;
    int           ev;
    logic [W-1:0] d;
    b = 0;
    while (b < len) begin
      if (rst_at >= 0 && b == rst_at) begin
        apply_reset(2);
        return;
      end
      v = ($urandom_range(0, 3) != 0);
      d = (kind == 0) ? W'(b + 1) : W'($urandom);
      step(v, d, v && (b == len - 1), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), acc, ev);
      if (acc) b++;
      if (ev == 1) armed(k);
    end
  endtask

  initial begin
    int len;
    int k;
    int r;
    rst        = 1'b1;
    cfg_tvalid = 1'b0;
    cfg_tdata  = '0;
    cfg_tlast  = 1'b0;
    sample_en  = 1'b0;
    err_clr    = 1'b0;
    @(posedge clk);
    #1;
    idle(3, 1'b0);
    rst = 1'b0;

    send_set(T, 0, 0, -1);          // ramp set, FIR idle: quick swap
    idle(4, 1'b0);
    send_set(T, 1, 5000, -1);       // FIR busy throughout: forced swap
    idle(3, 1'b0);
    send_set(50, 1, 0, -1);         // short set
    idle(3, 1'b0);
    idle(1, 1'b1);                  // clear errors
    idle(2, 1'b0);
    send_set(130, 1, 0, -1);        // long set
    idle(3, 1'b0);
    send_set(T, 1, 2, -1);
    send_set(T, 1, 0, 60);          // reset mid-load
    send_set(T, 0, 0, -1);
    send_set(T, 1, 1, -1);          // back-to-back A then B
    send_set(T, 1, 1, -1);
    idle(2, 1'b0);

    for (int s = 0; s < 16; s++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       len = T;
      else if (r < 8)  len = $urandom_range(1, T - 1);
      else             len = $urandom_range(T + 1, T + 12);
      r = $urandom_range(0, 9);
      if (r < 6)       k = r;
      else if (r == 6) k = $urandom_range(TO - 2, TO + 1);
      else if (r == 7) k = $urandom_range(0, 40);
      else             k = 0;
      send_set(len, 1, k, -1);
      idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    idle(10, 1'b0);
    chk("queue_empty", sq.size() == 0, sq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Coefficient bank controller for the dual-channel decimating FIR. It accepts a new 121-tap coefficient set over a streaming config port into a shadow bank. It then swaps shadow and active banks atomically on a cycle when the FIR is not consuming a sample. The active bank drives the FIR's shared coefficient bus, so coefficients can be reloaded at run time without stopping the sample stream.

## Interface
- TAP_COUNT, 121, number of coefficients per bank
- COEF_WIDTH, 16, signed coefficient width
- SWAP_TIMEOUT, 1024, max ARMED cycles with sample_en high before a forced swap (≥2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_tvalid  in  1  config beat valid
- cfg_tready  out  1  config beat accepted when valid&&ready
- cfg_tdata  in  COEF_WIDTH  coefficient, tap 0 first
- cfg_tlast  in  1  marks final coefficient of a set
- sample_en  in  1  FIR consumes a sample this cycle (its s_tvalid&&s_tready)
- coef_bus  out  TAP_COUNT*COEF_WIDTH  active bank, tap k at [k*COEF_WIDTH +: COEF_WIDTH]
- bank_sel  out  1  index of active bank
- swap_done  out  1  one-cycle pulse, first cycle new bank is active
- swap_forced  out  1  one-cycle pulse with swap_done when swap came from timeout
- err_short  out  1  sticky: tlast before TAP_COUNT beats
- err_long  out  1  sticky: more than TAP_COUNT beats before tlast
- err_clr  in  1  clears both sticky errors

## Operation
- Two register banks of TAP_COUNT×COEF_WIDTH. coef_bus = bank[bank_sel], combinational mux of registers. Shadow = bank[!bank_sel].
- States: IDLE, LOAD, DRAIN, ARMED. cfg_tready = 1 in IDLE/LOAD/DRAIN, 0 in ARMED, 0 while rst high.
- IDLE: an accepted beat writes shadow[0], idx←1. With tlast (and TAP_COUNT>1): err_short, stay IDLE. Otherwise go to LOAD.
- LOAD: each accepted beat writes shadow[idx], idx++.
  - tlast with idx==TAP_COUNT-1 → ARMED.
  - tlast with idx<TAP_COUNT-1 → err_short, IDLE; shadow contents don't care, no swap.
  - Beat at idx==TAP_COUNT-1 without tlast → write it, go to DRAIN.
- DRAIN: accept and discard beats; on tlast set err_long and go to IDLE; no swap.
- ARMED: timer counts cycles with sample_en high.
  - Exit when sample_en==0, or when timer==SWAP_TIMEOUT-1 with sample_en high.
  - On exit: bank_sel toggles, swap_done pulses next cycle, swap_forced pulses on timeout exit, timer←0, state←IDLE.
- Swap never occurs on a cycle where sample_en is high, except forced.
- Errors: a set event and err_clr in the same cycle → error stays set (set wins).
- The active bank is never written. A partial or aborted load never changes coef_bus.
- idx width = $clog2(TAP_COUNT); timer width = $clog2(SWAP_TIMEOUT).

## Timing
- Reset values:
  - State IDLE, bank_sel=0, both banks all zero, so coef_bus=0.
  - swap_done=0, swap_forced=0, err_short=0, err_long=0, idx=0, timer=0.
  - cfg_tready=0 during rst, 1 the first cycle after.
- Reset mid-LOAD, DRAIN or ARMED aborts with no swap and clears both banks.
- Beat with tlast accepted at cycle N → ARMED at N+1.
  - sample_en low at N+1 → bank_sel toggled and swap_done=1 at N+2; cfg_tready=1 at N+2.
  - sample_en held high → swap at N+1+SWAP_TIMEOUT with swap_forced=1.
- One beat accepted per cycle max; idle cycles (cfg_tvalid=0) mid-load are allowed without limit.
- coef_bus changes only in the cycle swap_done is high.
- swap_done and swap_forced are registered outputs.

## Test plan
- After reset, load 121 beats with value k+1 (tlast on beat 121), sample_en=0 → swap_done one cycle after ARMED; bank_sel=1; tap 0 = 0x0001, tap 120 = 0x0079; no errors.
- Same load with sample_en held high → swap_done and swap_forced at exactly SWAP_TIMEOUT cycles after ARMED entry; coef_bus changes only then.
- Load 50 beats, tlast on beat 50 → err_short=1, state IDLE, bank_sel and coef_bus unchanged. Pulse err_clr → err_short=0.
- Load 130 beats, tlast on beat 130 → cfg_tready=1 throughout, err_long=1, no swap. A following correct 121-beat load swaps normally.
- Assert rst at beat 60 of a load → all outputs at reset values, coef_bus=0. A subsequent full load swaps to bank 1.
- Back-to-back loads A then B, sample_en toggling 1,0 → cfg_tready=0 while ARMED. Second swap returns bank_sel to 0 with B values, and A stays in the shadow bank.
